// File: rtl/blur_frame_io.sv
// rtl/blur_frame_io.sv - frame sequencer: loads pixels into RAM A, hands RAM A to the blur engine, streams the result out.
module blur_frame_io #(
    parameter int IMG_W = 210,
    parameter int IMG_H = 300,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iStart,
    input  logic          iInValid,
    output logic          oInReady,
    input  logic [DW-1:0] iInData,
    output logic          oOutValid,
    input  logic          iOutReady,
    output logic [DW-1:0] oOutData,
    output logic          oOutLast,
    output logic [AW-1:0] oAddr,
    output logic          oWren,
    output logic [DW-1:0] oWrData,
    input  logic [DW-1:0] iRdData,
    output logic          oRamOwn,
    output logic          oBlurEna,
    input  logic          iBlurDone,
    output logic          oBusy,
    output logic          oDone
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam logic [CW-1:0] LAST_C = CW'(NPIX - 1);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_READ,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem0_q, mem0_d;
    logic [DW-1:0] mem1_q, mem1_d;

    logic          in_xfer;
    logic          out_xfer;
    logic          issue;
    logic [2:0]    level;
    logic [DW-1:0] head;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        out_cnt_d  = out_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem0_d     = mem0_q;
        mem1_d     = mem1_q;
        oAddr      = '0;
        oWren      = 1'b0;
        oWrData    = '0;
        oRamOwn    = 1'b0;
        oBlurEna   = 1'b0;
        oDone      = 1'b0;
        oBusy      = (state_q != S_IDLE);

        // a reset edge must not also commit a write, so the input side is gated by iRST_N
        oInReady   = (state_q == S_LOAD) && iRST_N;
        in_xfer    = oInReady && iInValid;

        head       = rd_ptr_q ? mem1_q : mem0_q;
        oOutValid  = (count_q != 2'd0);
        oOutData   = oOutValid ? head : '0;
        oOutLast   = oOutValid && (out_cnt_q == LAST_C);
        out_xfer   = oOutValid && iOutReady;

        // buffered + in flight after this cycle's pop; keeping it below 2 bounds the skid at 2 entries
        level      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, out_xfer};
        issue      = (state_q == S_READ) && (level < 3'd2) && (pix_cnt_q < NPIX_C);
        inflight_d = issue;

        if (inflight_q) begin
            if (wr_ptr_q) mem1_d = iRdData;
            else          mem0_d = iRdData;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (out_xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, inflight_q} - {1'b0, out_xfer};

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d   = S_LOAD;
                    pix_cnt_d = '0;
                end
            end
            S_LOAD: begin
                oRamOwn = 1'b1;
                if (in_xfer) begin
                    oWren     = 1'b1;
                    oAddr     = AW'(pix_cnt_q);
                    oWrData   = iInData;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_C) begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK: begin
                oBlurEna = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (iBlurDone) begin
                    state_d   = S_READ;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
                end
            end
            S_READ: begin
                oRamOwn = 1'b1;
                if (issue) begin
                    oAddr     = AW'(pix_cnt_q);
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (out_xfer) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (oOutLast) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                oDone   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem0_q     <= '0;
            mem1_q     <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
        end
    end

endmodule

// File: tb/tb_blur_frame_io.sv
// tb/tb_blur_frame_io.sv - directed bench for blur_frame_io on a 6x5 frame with RAM and blur-engine models.
module tb_blur_frame_io;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam logic [DW-1:0] XFORM = 16'h5A5A;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iStart = 1'b0;
    logic          iInValid = 1'b0;
    logic [DW-1:0] iInData = '0;
    logic          iOutReady = 1'b0;
    logic          iBlurDone = 1'b0;
    logic [DW-1:0] iRdData;
    logic          oInReady, oOutValid, oOutLast, oWren, oRamOwn, oBlurEna, oBusy, oDone;
    logic [DW-1:0] oOutData, oWrData;
    logic [AW-1:0] oAddr;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    logic do_xform = 1'b0;
    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] rd_q = '0;

    blur_frame_io #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart),
        .iInValid(iInValid), .oInReady(oInReady), .iInData(iInData),
        .oOutValid(oOutValid), .iOutReady(iOutReady), .oOutData(oOutData), .oOutLast(oOutLast),
        .oAddr(oAddr), .oWren(oWren), .oWrData(oWrData), .iRdData(iRdData),
        .oRamOwn(oRamOwn), .oBlurEna(oBlurEna), .iBlurDone(iBlurDone),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iCLK = ~iCLK;

    // RAM A with synchronous read; the blur engine is modelled as an in-place XOR while it owns the RAM
    always @(posedge iCLK) begin
        if (do_xform) begin
            for (int i = 0; i < N; i++) ram[i] <= ram[i] ^ XFORM;
        end else if (oWren) begin
            ram[oAddr[5:0]] <= oWrData;
            wr_count <= wr_count + 1;
        end
        rd_q <= ram[oAddr[5:0]];
    end
    assign iRdData = rd_q;

    function automatic logic [DW-1:0] pix(input int i);
        return 16'h1000 + 16'(i * 37);
    endfunction

    task automatic test_reset();
        iRST_N = 1'b0; iStart = 1'b1; iInValid = 1'b1; iInData = 16'hFFFF; iOutReady = 1'b1; iBlurDone = 1'b1;
        repeat (2) @(negedge iCLK);
        #1;
        vectors++;
        if ({oInReady, oOutValid, oOutLast, oWren, oBlurEna, oDone, oBusy, oRamOwn} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000000",
                     {oInReady, oOutValid, oOutLast, oWren, oBlurEna, oDone, oBusy, oRamOwn});
        end
        vectors++;
        if (oAddr !== 16'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0000", oAddr); end
        vectors++;
        if (oWrData !== 16'h0) begin miscompares++; $display("FAIL reset_wrdata got %h want 0000", oWrData); end
        vectors++;
        if (oOutData !== 16'h0) begin miscompares++; $display("FAIL reset_outdata got %h want 0000", oOutData); end
        iStart = 1'b0; iInValid = 1'b0; iInData = '0; iBlurDone = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        #1;
        vectors++;
        if (oBusy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", oBusy); end
    endtask

    task automatic run_frame(input string name, input bit gaps, input bit rnd_rdy, input bit poke);
        int in_idx = 0, out_idx = 0, blur_cnt = 0, ena_cnt = 0, done_cnt = 0;
        int bdone_cyc = -1, first_out = -1, last_out = -1, wr_base;
        bit finished = 1'b0, in_wait = 1'b0, prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        wr_base = wr_count;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge iCLK);
            do_xform  = 1'b0;
            iStart    = (cyc == 0) || (poke && (cyc == 4 || out_idx == 5));
            iInValid  = gaps ? (cyc % 2 == 1) : 1'b1;
            iInData   = iInValid ? pix(in_idx) : 16'hDEAD;
            iOutReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            iBlurDone = 1'b0;
            if (blur_cnt > 0) begin
                blur_cnt--;
                if (blur_cnt == 0) begin
                    iBlurDone = 1'b1;
                    do_xform  = 1'b1;
                    bdone_cyc = cyc;
                end
            end else if (poke && cyc == 6) begin
                iBlurDone = 1'b1;
            end
            #1;
            vectors++;
            if (oWren !== (iInValid && oInReady)) begin
                miscompares++;
                $display("FAIL %s wren_gate cyc %0d got %b want %b", name, cyc, oWren, iInValid && oInReady);
            end
            if (oWren && !oRamOwn) begin
                vectors++; miscompares++;
                $display("FAIL %s own_wr cyc %0d got ramown 0 want 1", name, cyc);
            end
            if (iInValid && oInReady) begin
                vectors++;
                if (oAddr !== 16'(in_idx) || oWrData !== pix(in_idx)) begin
                    miscompares++;
                    $display("FAIL %s write got %h/%h want %h/%h", name, oAddr, oWrData, 16'(in_idx), pix(in_idx));
                end
                in_idx++;
            end
            if (in_wait) begin
                vectors++;
                if (oRamOwn !== 1'b0 || oWren !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s wait_own got own %b wren %b want 0 0", name, oRamOwn, oWren);
                end
            end
            if (oBlurEna) begin
                ena_cnt++;
                vectors++;
                if (oRamOwn !== 1'b0 || in_idx != N) begin
                    miscompares++;
                    $display("FAIL %s kick got own %b loaded %0d want 0 %0d", name, oRamOwn, in_idx, N);
                end
                blur_cnt = 10;
            end
            if (oOutValid) begin
                if (prev_stall) begin
                    vectors++;
                    if (oOutData !== prev_data) begin
                        miscompares++;
                        $display("FAIL %s stall_hold got %h want %h", name, oOutData, prev_data);
                    end
                end
                if (iOutReady) begin
                    vectors++;
                    if (oOutData !== (pix(out_idx) ^ XFORM) || oOutLast !== (out_idx == N - 1)) begin
                        miscompares++;
                        $display("FAIL %s out[%0d] got %h last %b want %h last %b", name, out_idx,
                                 oOutData, oOutLast, pix(out_idx) ^ XFORM, out_idx == N - 1);
                    end
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    out_idx++;
                end
            end
            prev_stall = oOutValid && !iOutReady;
            prev_data  = oOutData;
            if (oDone) begin
                done_cnt++;
                vectors++;
                if (oRamOwn !== 1'b0 || out_idx != N) begin
                    miscompares++;
                    $display("FAIL %s fin got own %b outs %0d want 0 %0d", name, oRamOwn, out_idx, N);
                end
                finished = 1'b1;
            end
            if (iBlurDone && in_wait) in_wait = 1'b0;
            if (oBlurEna) in_wait = 1'b1;
        end
        @(negedge iCLK);
        iStart = 1'b0; iInValid = 1'b0; iBlurDone = 1'b0; do_xform = 1'b0;
        #1;
        vectors++;
        if (!finished) begin miscompares++; $display("FAIL %s timeout got no oDone want oDone", name); end
        vectors++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_fin got done %b busy %b want 0 0", name, oDone, oBusy);
        end
        vectors++;
        if (ena_cnt != 1 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s pulses got ena %0d done %0d want 1 1", name, ena_cnt, done_cnt);
        end
        vectors++;
        if (wr_count - wr_base != N || out_idx != N) begin
            miscompares++;
            $display("FAIL %s counts got wr %0d out %0d want %0d %0d", name, wr_count - wr_base, out_idx, N, N);
        end
        if (!rnd_rdy) begin
            vectors++;
            if (first_out != bdone_cyc + 3 || last_out != bdone_cyc + 2 + N) begin
                miscompares++;
                $display("FAIL %s latency got first %0d last %0d want %0d %0d", name, first_out, last_out,
                         bdone_cyc + 3, bdone_cyc + 2 + N);
            end
        end
    endtask

    task automatic test_full_frame();   run_frame("full",   1'b0, 1'b0, 1'b0); endtask
    task automatic test_input_gaps();   run_frame("gaps",   1'b1, 1'b0, 1'b0); endtask
    task automatic test_random_ready(); run_frame("rndrdy", 1'b0, 1'b1, 1'b0); endtask
    task automatic test_spurious();     run_frame("poke",   1'b1, 1'b1, 1'b1); endtask

    task automatic test_mid_reset();
        int wr_base;
        wr_base = wr_count;
        @(negedge iCLK);
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iInValid = 1'b1; iInData = pix(i);
            @(negedge iCLK);
        end
        iRST_N = 1'b0; iInValid = 1'b1; iInData = 16'hBEEF;
        @(negedge iCLK);
        #1;
        vectors++;
        if ({oInReady, oOutValid, oOutLast, oWren, oBlurEna, oDone, oBusy, oRamOwn} !== 8'h00
            || oAddr !== 16'h0 || oWrData !== 16'h0 || oOutData !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs got flags %b addr %h wd %h od %h want all 0",
                     {oInReady, oOutValid, oOutLast, oWren, oBlurEna, oDone, oBusy, oRamOwn},
                     oAddr, oWrData, oOutData);
        end
        vectors++;
        if (wr_count - wr_base != 10) begin
            miscompares++;
            $display("FAIL midrst_writes got %0d want 10", wr_count - wr_base);
        end
        iRST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            #1;
            vectors++;
            if (oWren !== 1'b0 || oBusy !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet got wren %b busy %b want 0 0", oWren, oBusy);
            end
        end
        iInValid = 1'b0;
        run_frame("restart", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_input_gaps();
        test_random_ready();
        test_spurious();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blur_frame_io.md
BLUR_FRAME_IO -- requirements
Module: blur_frame_io

Interface
REQ-001 SHALL have parameter IMG_W, default 210, meaning frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 300, meaning frame height in pixels.
REQ-003 SHALL have parameter DW, default 16, meaning pixel width; AW, default 16, meaning RAM address width.
REQ-004 iCLK  input  1  clock; all logic on the rising edge.
REQ-005 iRST_N  input  1  reset: synchronous, active-low.
REQ-006 iStart  input  1  starts one frame cycle (load, blur, readout); sampled only in IDLE.
REQ-007 iInValid / oInReady  input / output  1 / 1  pixel-in handshake; iInData  input  DW  raster-order pixel.
REQ-008 oOutValid / iOutReady  output / input  1 / 1  pixel-out handshake; oOutData  output  DW; oOutLast  output  1  marks the final pixel.
REQ-009 oAddr  output  AW, oWren  output  1, oWrData  output  DW, iRdData  input  DW  RAM-A port; synchronous read, data valid one cycle after address.
REQ-010 oRamOwn  output  1  high when this block drives RAM A; low hands RAM A to the blur engine.
REQ-011 oBlurEna  output  1  blur start pulse; iBlurDone  input  1  blur completion pulse.
REQ-012 oBusy  output  1  high in any non-IDLE state; oDone  output  1  one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement states IDLE, LOAD, KICK, WAIT, READ, FIN.
REQ-014 IDLE: iStart=1 -> LOAD with pixel counter=0; otherwise stay.
REQ-015 LOAD: oInReady=1, oRamOwn=1; each iInValid&oInReady cycle drives oWren=1, oAddr=counter, oWrData=iInData, then counter+1; oWren=0 on cycles without a transfer.
REQ-016 LOAD: the transfer at counter=IMG_W*IMG_H-1 (62999) -> KICK next cycle; oInReady=0 outside LOAD.
REQ-017 KICK: oBlurEna=1 for exactly one cycle, oRamOwn=0 -> WAIT.
REQ-018 WAIT: oRamOwn=0, oWren=0; iBlurDone=1 -> READ with read and output counters=0; iBlurDone outside WAIT is ignored.
REQ-019 READ: oRamOwn=1, oWren=0; issue a read (oAddr=read counter, then increment) only when skid occupancy + reads in flight < 2 and read counter <= 62999.
REQ-020 Read data SHALL enter a 2-entry skid FIFO the cycle after issue; oOutValid = FIFO non-empty; oOutData = FIFO head.
REQ-021 oOutData SHALL stay stable while oOutValid=1 and iOutReady=0; no pixel dropped or duplicated.
REQ-022 With iOutReady held high, first oOutValid SHALL occur 2 cycles after entering READ, then one pixel per cycle.
REQ-023 oOutLast=1 exactly with output pixel 62999; its transfer -> FIN.
REQ-024 FIN: oDone=1 for one cycle, oRamOwn=0 -> IDLE.
REQ-025 iStart outside IDLE SHALL be ignored; simultaneous iInValid and state exit SHALL not write beyond address 62999.
REQ-026 Counters SHALL be sized for IMG_W*IMG_H and never wrap within a frame.

Reset
REQ-027 iRST_N=0 SHALL force, next edge: state IDLE, counters 0, FIFO empty, in-flight cleared; oInReady, oOutValid, oOutLast, oWren, oBlurEna, oDone, oBusy, oRamOwn = 0; oAddr, oWrData, oOutData = 0.
REQ-028 Reset mid-frame (any state) SHALL abandon the frame; no further RAM write or output pixel until a new iStart.

Verification
REQ-029 Full frame, iInValid=1 continuous, blur model echoes iBlurDone 10 cycles after oBlurEna, iOutReady=1 -> 63000 writes at addresses 0..62999, one oBlurEna pulse, 63000 outputs equal to RAM contents in order, oOutLast on the last, oDone one cycle.
REQ-030 Input gaps (iInValid toggling 1/0) -> oWren only on valid cycles, no address skipped; KICK reached only after pixel 62999.
REQ-031 Random iOutReady (50%) -> output sequence identical to REQ-029, oOutData stable during stalls, no more than 2 reads outstanding+buffered.
REQ-032 iStart pulses during LOAD and READ, spurious iBlurDone during LOAD -> no effect; frame completes normally.
REQ-033 iRST_N=0 after 1000 loaded pixels -> all outputs 0 next cycle; new iStart restarts writes at address 0.
REQ-034 Ownership check: oRamOwn=0 from KICK through WAIT and in FIN, oWren never 1 while oRamOwn=0.
